// File: rtl/bios_stream_loader_pkg.sv
// bios_loader_pkg: drain states and buffer constants shared by the BIOS loader
package bios_loader_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FINISH} drain_t;
  localparam int HALF_WORDS_LOG2 = 5;
  localparam int BUF_WORDS = 64;
  localparam logic [15:0] PAD_WORD_DEF = 16'hFFFF;
endpackage

// File: rtl/bios_stream_loader_ram.sv
// bios_pingpong_ram: simple dual-port word buffer with registered 1-cycle read
module bios_pingpong_ram import bios_loader_pkg::*; #(
  parameter int DEPTH = BUF_WORDS,
  parameter int AW = HALF_WORDS_LOG2 + 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   q
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/bios_stream_loader.sv
// bios_stream_loader: pairs ioctl bytes into a ping-pong buffer and streams words to the BIOS port
module bios_stream_loader import bios_loader_pkg::*; #(
  parameter int          HALF_WORDS = 32,
  parameter int          ADDR_W     = 14,
  parameter logic [15:0] PAD_WORD   = PAD_WORD_DEF
) (
  input  logic              clk_sdr,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              bios_req,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_wr,
  output logic              bios_loaded,
  output logic              overrun
);
  localparam int HL = $clog2(HALF_WORDS);
  drain_t state, state_n;
  logic dl_q, active, rel, whalf;
  logic [7:0] lo;
  logic [1:0] full;
  logic [HL:0] cnt [2];
  logic [HL:0] wcnt, rp, rp_n;
  logic [15:0] q;
  logic rise, fall, hb, en, we, fire, last, unused_addr;
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q & active;
  assign hb = ioctl_addr[HL+1];
  assign en = active & ioctl_download & ioctl_wr & ~rise;
  assign we = en & ioctl_addr[0] & ~full[hb];
  assign fire = (state == STREAM) & bios_req & full[rp[HL]];
  assign last = fire & (&rp[HL-1:0]);
  assign rp_n = rise ? '0 : rp + (HL+1)'(fire);
  assign unused_addr = ^ioctl_addr[24:HL+2];
  assign bios_wr = state == STREAM;
  assign bios_loaded = state == FINISH;
  bios_pingpong_ram #(.DEPTH(2*HALF_WORDS), .AW(HL+1)) ram (
    .clk(clk_sdr), .we(we), .waddr(ioctl_addr[HL+1:1]), .wdata({ioctl_dout, lo}),
    .raddr(rp_n), .q(q)
  );
  always_ff @(posedge clk_sdr) begin
    dl_q <= reset | ioctl_download;
    state <= reset ? IDLE : state_n;
    if (reset | rise) begin
      active <= ~reset;
      full <= '0;
      rel <= 1'b0;
      rp <= '0;
      bios_addr <= '0;
      overrun <= 1'b0;
      wcnt <= '0;
      if (reset) begin
        lo <= '0;
        bios_din <= '0;
      end
    end else begin
      if (fall) active <= 1'b0;
      if (fire) begin
        rp <= rp + 1'b1;
        bios_addr <= bios_addr + 1'b1;
        bios_din <= ({1'b0, rp[HL-1:0]} >= cnt[rp[HL]]) ? PAD_WORD : q;
      end
      if (last) begin
        full[rp[HL]] <= 1'b0;
        rel <= 1'b1;
      end else if (state == STREAM & ~bios_req) rel <= 1'b0;
      if (en & full[hb]) overrun <= 1'b1;
      if (en & ~ioctl_addr[0] & ~full[hb]) lo <= ioctl_dout;
      if (we) begin
        whalf <= hb;
        if (&ioctl_addr[HL:1]) begin
          full[hb] <= 1'b1;
          cnt[hb] <= (HL+1)'(HALF_WORDS);
          wcnt <= '0;
        end else wcnt <= (HL+1)'(ioctl_addr[HL:1]) + 1'b1;
      end
      if (fall & (|wcnt)) begin
        full[whalf] <= 1'b1;
        cnt[whalf] <= wcnt;
        wcnt <= '0;
      end
    end
  end
  always_comb begin
    state_n = rise ? IDLE :
              state == IDLE ? (full[rp[HL]] ? STREAM : IDLE) :
              state == STREAM ? ((rel & ~bios_req) ? (full[rp[HL]] ? STREAM : (~active & ~(|full)) ? FINISH : IDLE) : STREAM) :
              FINISH;
  end
endmodule
